adc_udp_framer: RTL

ADC_UDP_FRAMER -- requirements
Module: adc_udp_framer

---
 rtl/adc_eth_pkg.sv | 21 ++
 rtl/adc_udp_framer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adc_eth_pkg.sv
// Shared types and protocol constants for the ADC-to-UDP framer.
package adc_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_DATA
  } framer_state_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam int          UDP_HDR_BYTES = 8;
  localparam int          SEQ_BYTES     = 4;

  // UDP length field: UDP header + sequence word + two bytes per sample.
  function automatic logic [15:0] udp_len(input int samples);
    return 16'(UDP_HDR_BYTES + SEQ_BYTES + 2 * samples);
  endfunction

endpackage

// File: rtl/adc_udp_framer.sv
// Packs 16-bit ADC samples into UDP datagrams: header handshake, 32-bit
// big-endian sequence number, then samples high byte first.
//
// state | meaning
// IDLE  | waiting for enable to start a datagram
// HDR   | presenting header fields until the UDP stack accepts them
// SEQ   | sending the four sequence-number bytes
// DATA  | streaming samples; phase 0 = high byte, phase 1 = captured low byte
module adc_udp_framer
  import adc_eth_pkg::*;
#(
  parameter int          SAMPLES_PER_PKT = 256,
  parameter logic [47:0] LOCAL_MAC       = 48'h02_00_00_00_00_00,
  parameter logic [47:0] DEST_MAC        = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] LOCAL_IP        = 32'hC0A8_0180,
  parameter logic [31:0] DEST_IP         = 32'hC0A8_0101,
  parameter logic [15:0] SRC_PORT        = 16'd1234,
  parameter logic [15:0] DEST_PORT       = 16'd1234,
  // Value seq_num takes on reset; nonzero only for bring-up of wrap behaviour.
  parameter logic [31:0] SEQ_RESET       = 32'h0000_0000
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic        enable,

  input  logic [15:0] s_adc_tdata,
  input  logic        s_adc_tvalid,
  output logic        s_adc_tready,

  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [3:0]  m_ip_version,
  output logic [3:0]  m_ip_ihl,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [15:0] m_ip_identification,
  output logic [2:0]  m_ip_flags,
  output logic [12:0] m_ip_fragment_offset,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [15:0] m_ip_header_checksum,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,

  output logic [7:0]  m_udp_payload_axis_tdata,
  output logic        m_udp_payload_axis_tvalid,
  input  logic        m_udp_payload_axis_tready,
  output logic        m_udp_payload_axis_tlast,
  output logic        m_udp_payload_axis_tuser,

  output logic        busy,
  output logic [31:0] seq_num
);

  localparam int          CNT_W       = 10;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_PKT - 1);

  framer_state_t    state_q, state_d;
  logic [31:0]      seq_q, seq_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       low_q, low_d;

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state_q      <= ST_IDLE;
      seq_q        <= SEQ_RESET;
      byte_idx_q   <= '0;
      sample_cnt_q <= '0;
      phase_q      <= 1'b0;
      low_q        <= '0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      byte_idx_q   <= byte_idx_d;
      sample_cnt_q <= sample_cnt_d;
      phase_q      <= phase_d;
      low_q        <= low_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    seq_d                     = seq_q;
    byte_idx_d                = byte_idx_q;
    sample_cnt_d              = sample_cnt_q;
    phase_d                   = phase_q;
    low_d                     = low_q;
    m_udp_hdr_valid           = 1'b0;
    s_adc_tready              = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tdata  = 8'h00;
    m_udp_payload_axis_tlast  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_HDR;
      end

      ST_HDR: begin
        m_udp_hdr_valid = 1'b1;
        if (m_udp_hdr_ready) begin
          state_d    = ST_SEQ;
          byte_idx_d = '0;
        end
      end

      ST_SEQ: begin
        m_udp_payload_axis_tvalid = 1'b1;
        case (byte_idx_q)
          2'd0:    m_udp_payload_axis_tdata = seq_q[31:24];
          2'd1:    m_udp_payload_axis_tdata = seq_q[23:16];
          2'd2:    m_udp_payload_axis_tdata = seq_q[15:8];
          default: m_udp_payload_axis_tdata = seq_q[7:0];
        endcase
        if (m_udp_payload_axis_tready) begin
          if (byte_idx_q == 2'd3) begin
            state_d      = ST_DATA;
            sample_cnt_d = '0;
            phase_d      = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      ST_DATA: begin
        if (!phase_q) begin
          // High byte passes straight through so the ADC sees real backpressure.
          s_adc_tready              = m_udp_payload_axis_tready;
          m_udp_payload_axis_tvalid = s_adc_tvalid;
          m_udp_payload_axis_tdata  = s_adc_tdata[15:8];
          if (s_adc_tvalid && m_udp_payload_axis_tready) begin
            low_d   = s_adc_tdata[7:0];
            phase_d = 1'b1;
          end
        end else begin
          m_udp_payload_axis_tvalid = 1'b1;
          m_udp_payload_axis_tdata  = low_q;
          m_udp_payload_axis_tlast  = (sample_cnt_q == LAST_SAMPLE);
          if (m_udp_payload_axis_tready) begin
            phase_d = 1'b0;
            if (sample_cnt_q == LAST_SAMPLE) begin
              state_d      = ST_IDLE;
              sample_cnt_d = '0;
              seq_d        = seq_q + 32'd1;
            end else begin
              sample_cnt_d = sample_cnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign m_eth_dest_mac       = DEST_MAC;
  assign m_eth_src_mac        = LOCAL_MAC;
  assign m_eth_type           = ETH_TYPE_IPV4;
  assign m_ip_version         = 4'd4;
  assign m_ip_ihl             = 4'd5;
  assign m_ip_dscp            = 6'd0;
  assign m_ip_ecn             = 2'd0;
  assign m_ip_identification  = seq_q[15:0];
  assign m_ip_flags           = 3'b010;
  assign m_ip_fragment_offset = 13'd0;
  assign m_ip_ttl             = 8'd64;
  assign m_ip_protocol        = IP_PROTO_UDP;
  assign m_ip_header_checksum = 16'd0;
  assign m_ip_source_ip       = LOCAL_IP;
  assign m_ip_dest_ip         = DEST_IP;
  assign m_udp_source_port    = SRC_PORT;
  assign m_udp_dest_port      = DEST_PORT;
  assign m_udp_length         = udp_len(SAMPLES_PER_PKT);
  assign m_udp_checksum       = 16'd0;

  assign m_udp_payload_axis_tuser = 1'b0;
  assign busy                     = (state_q != ST_IDLE);
  assign seq_num                  = seq_q;

endmodule
